// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for a valid/ready native memory bus.
// One transaction in flight at a time; the request fields are latched at grant.
// A hung slave is released by a forced completion that returns ErrData.
module mem_bus_arbiter #(
   parameter int unsigned TimeoutCycles = 1024,
   parameter logic [31:0] ErrData       = 32'hFFFF_FFFF
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        m0_valid_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_wdata_i,
   input  logic [3:0]  m0_wstrb_i,
   output logic [31:0] m0_rdata_o,
   output logic        m0_ready_o,
   input  logic        m1_valid_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_wdata_i,
   input  logic [3:0]  m1_wstrb_i,
   output logic [31:0] m1_rdata_o,
   output logic        m1_ready_o,
   output logic        s_valid_o,
   output logic [31:0] s_addr_o,
   output logic [31:0] s_wdata_o,
   output logic [3:0]  s_wstrb_o,
   input  logic [31:0] s_rdata_i,
   input  logic        s_ready_i,
   output logic        grant_o,
   output logic        busy_o,
   output logic        timeout_o
);

   // Width of a counter that can reach TimeoutCycles; kept at 1 bit when disabled
   localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t            state;
   logic              grant;
   logic              last_grant;
   logic [CntW-1:0]   cnt;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;
   logic              timeout_q;

   logic              req_any;
   logic              pick;
   logic              busy;
   logic              tmo_fire;
   logic              done;
   logic [31:0]       rsp_data;

   // Arbitration choice, completion detection and master-side responses
   always_comb begin
      req_any  = m0_valid_i | m1_valid_i;
      pick     = (m0_valid_i && m1_valid_i) ? ~last_grant : m1_valid_i;
      busy     = (state == BUSY);
      // slave completion takes priority over a timeout landing in the same cycle
      tmo_fire = busy && !s_ready_i && (TimeoutCycles != 0) && (cnt == CntLast);
      done     = busy && (s_ready_i || tmo_fire);
      rsp_data = s_ready_i ? s_rdata_i : ErrData;

      m0_ready_o = done && !grant;
      m1_ready_o = done && grant;
      m0_rdata_o = m0_ready_o ? rsp_data : '0;
      m1_rdata_o = m1_ready_o ? rsp_data : '0;

      s_valid_o  = busy;
      s_addr_o   = addr_q;
      s_wdata_o  = wdata_q;
      s_wstrb_o  = wstrb_q;
      grant_o    = grant;
      busy_o     = busy;
      timeout_o  = timeout_q;
   end

   // Grant/complete state machine with latched request fields and timeout counter
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         timeout_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_any) begin
                  grant      <= pick;
                  last_grant <= pick;
                  cnt        <= '0;
                  addr_q     <= pick ? m1_addr_i  : m0_addr_i;
                  wdata_q    <= pick ? m1_wdata_i : m0_wdata_i;
                  wstrb_q    <= pick ? m1_wstrb_i : m0_wstrb_i;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != '1) begin
                  cnt <= cnt + 1'b1;
               end
               if (tmo_fire) begin
                  timeout_q <= 1'b1;
               end
               if (done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a vector table for round-robin behaviour
// plus hand-written sequences for read latency, write latching, timeout,
// the timeout/ready tie and asynchronous reset during a transaction.
module tb_mem_bus_arbiter;

   localparam int unsigned TO = 8;
   localparam logic [31:0] ERR = 32'hFFFF_FFFF;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        m0_valid_i, m1_valid_i;
   logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
   logic [3:0]  m0_wstrb_i, m1_wstrb_i;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        m0_ready_o, m1_ready_o;
   logic        s_valid_o;
   logic [31:0] s_addr_o, s_wdata_o;
   logic [3:0]  s_wstrb_o;
   logic [31:0] s_rdata_i;
   logic        s_ready_i;
   logic        grant_o, busy_o, timeout_o;

   int checks = 0;
   int failures = 0;

   mem_bus_arbiter #(
      .TimeoutCycles(TO),
      .ErrData(ERR)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .m0_valid_i(m0_valid_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
      .m0_wstrb_i(m0_wstrb_i), .m0_rdata_o(m0_rdata_o), .m0_ready_o(m0_ready_o),
      .m1_valid_i(m1_valid_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
      .m1_wstrb_i(m1_wstrb_i), .m1_rdata_o(m1_rdata_o), .m1_ready_o(m1_ready_o),
      .s_valid_o(s_valid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
      .s_wstrb_o(s_wstrb_o), .s_rdata_i(s_rdata_i), .s_ready_i(s_ready_i),
      .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        m0v;
      logic        m1v;
      logic        sr;
      logic [31:0] srd;
      logic        busy;
      logic        gnt;
      logic        m0r;
      logic        m1r;
      logic [31:0] m0rd;
      logic [31:0] m1rd;
      logic [31:0] saddr;
   } vec_t;

   vec_t vecs[10];

   int          n;
   int          pulses;
   int          m1p;
   logic        seen;
   logic [100:0] act_v, exp_v;

   initial begin
      // both masters requesting, slave answers every BUSY cycle
      vecs[0] = '{1'b1, 1'b1, 1'b1, 32'hAAAA_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0,          32'h0};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 32'hAAAA_0001, 1'b1, 1'b0, 1'b1, 1'b0, 32'hAAAA_0001, 32'h0,          32'h100};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 32'hAAAA_0002, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0,          32'h100};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 32'hAAAA_0003, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,          32'hAAAA_0003, 32'h200};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 32'hAAAA_0004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0,          32'h200};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 32'hAAAA_0005, 1'b1, 1'b0, 1'b1, 1'b0, 32'hAAAA_0005, 32'h0,          32'h100};
      vecs[6] = '{1'b1, 1'b1, 1'b1, 32'hAAAA_0006, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0,          32'h100};
      vecs[7] = '{1'b1, 1'b1, 1'b1, 32'hAAAA_0007, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,          32'hAAAA_0007, 32'h200};
      vecs[8] = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0,          32'h200};
      vecs[9] = '{1'b0, 1'b0, 1'b1, 32'hBEEF_0009, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0,          32'h200};

      reset_i = 1'b1;
      m0_valid_i = 1'b0; m0_addr_i = '0; m0_wdata_i = '0; m0_wstrb_i = '0;
      m1_valid_i = 1'b0; m1_addr_i = '0; m1_wdata_i = '0; m1_wstrb_i = '0;
      s_rdata_i = '0; s_ready_i = 1'b0;

      // reset state
      @(negedge clk_i);
      chk("reset_state", 128'({s_valid_o, busy_o, grant_o, timeout_o, m0_ready_o, m1_ready_o,
                               m0_rdata_o, m1_rdata_o, s_addr_o, s_wdata_o, s_wstrb_o}), 128'd0);
      @(posedge clk_i); #1;
      reset_i = 1'b0;

      // round-robin vector table
      m0_addr_i = 32'h100;
      m1_addr_i = 32'h200;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_i); #1;
         m0_valid_i = vecs[i].m0v;
         m1_valid_i = vecs[i].m1v;
         s_ready_i  = vecs[i].sr;
         s_rdata_i  = vecs[i].srd;
         @(negedge clk_i);
         act_v = {busy_o, s_valid_o, (busy_o ? grant_o : 1'b0), m0_ready_o, m1_ready_o,
                  m0_rdata_o, m1_rdata_o, s_addr_o};
         exp_v = {vecs[i].busy, vecs[i].busy, vecs[i].gnt, vecs[i].m0r, vecs[i].m1r,
                  vecs[i].m0rd, vecs[i].m1rd, vecs[i].saddr};
         chk($sformatf("rr_vec%0d", i), 128'(act_v), 128'(exp_v));
      end

      // single read, slave answers on the third BUSY cycle
      m0_addr_i = 32'h0000_0010;
      pulses = 0; m1p = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk_i); #1;
         m0_valid_i = (k < 4);
         s_ready_i  = (k == 3);
         s_rdata_i  = 32'h1234_5678;
         @(negedge clk_i);
         if (m0_ready_o) begin
            pulses++;
            chk("rd_data", 128'(m0_rdata_o), 128'(32'h1234_5678));
            chk("rd_cycle", 128'(k), 128'(3));
         end
         if (m1_ready_o) m1p++;
         if (k == 1) chk("rd_addr", 128'({s_valid_o, s_addr_o}), 128'({1'b1, 32'h10}));
      end
      chk("rd_pulses", 128'(pulses), 128'(1));
      chk("rd_m1_quiet", 128'(m1p), 128'(0));

      // write from m1 with its inputs changing while BUSY
      for (int k = 0; k < 5; k++) begin
         @(posedge clk_i); #1;
         s_ready_i = (k == 3);
         s_rdata_i = 32'h0;
         if (k == 0) begin
            m1_valid_i = 1'b1; m1_addr_i = 32'h300; m1_wdata_i = 32'hA5A5_A5A5; m1_wstrb_i = 4'b0011;
         end else begin
            m1_valid_i = (k < 4); m1_addr_i = 32'hDEAD_0000 + 32'(k);
            m1_wdata_i = 32'h0; m1_wstrb_i = 4'b1111;
         end
         @(negedge clk_i);
         if (k >= 1 && k <= 3)
            chk($sformatf("wr_fields%0d", k), 128'({s_valid_o, grant_o, s_addr_o, s_wdata_o, s_wstrb_o}),
                128'({1'b1, 1'b1, 32'h300, 32'hA5A5_A5A5, 4'b0011}));
         if (k == 3) chk("wr_ready", 128'({m1_ready_o, m0_ready_o}), 128'(2'b10));
      end

      // tie: slave ready exactly when the counter reaches TO-1
      m1_addr_i = 32'h50;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk_i); #1;
         m1_valid_i = (k < 9);
         s_ready_i  = (k == 8);
         s_rdata_i  = 32'h7777_0008;
         @(negedge clk_i);
         if (k == 7) chk("tie_not_yet", 128'({busy_o, m1_ready_o}), 128'(2'b10));
         if (k == 8) chk("tie_data", 128'({m1_ready_o, m1_rdata_o}), 128'({1'b1, 32'h7777_0008}));
         if (k == 9) chk("tie_no_timeout", 128'({busy_o, timeout_o}), 128'(2'b00));
      end

      // timeout: slave never answers
      m0_addr_i = 32'h40;
      m0_valid_i = 1'b1;
      s_ready_i = 1'b0;
      n = 0; seen = 1'b0;
      @(posedge clk_i); #1;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk_i);
         if (busy_o) n++;
         if (n == 1 && busy_o) chk("to_flag_before", 128'(timeout_o), 128'(0));
         if (m0_ready_o) begin
            seen = 1'b1;
            chk("to_cycle", 128'(n), 128'(TO));
            chk("to_rdata", 128'({m0_rdata_o, m1_ready_o}), 128'({ERR, 1'b0}));
         end
         @(posedge clk_i); #1;
      end
      chk("to_seen", 128'(seen), 128'(1));
      m0_valid_i = 1'b0;
      @(negedge clk_i);
      chk("to_flag_set", 128'({busy_o, timeout_o}), 128'(2'b01));

      // normal transaction after the timeout; flag stays sticky
      for (int k = 0; k < 4; k++) begin
         @(posedge clk_i); #1;
         m0_valid_i = (k < 2);
         s_ready_i  = (k == 1);
         s_rdata_i  = 32'h600D_0001;
         @(negedge clk_i);
         if (k == 1) chk("post_to_read", 128'({m0_ready_o, m0_rdata_o, timeout_o}),
                         128'({1'b1, 32'h600D_0001, 1'b1}));
      end
      chk("to_sticky", 128'(timeout_o), 128'(1));

      // asynchronous reset in the middle of BUSY
      @(posedge clk_i); #1;
      m0_valid_i = 1'b1; s_ready_i = 1'b0;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("rst_busy_before", 128'(busy_o), 128'(1));
      #2;
      reset_i = 1'b1;
      #1;
      chk("rst_async", 128'({s_valid_o, busy_o, m0_ready_o, m1_ready_o, timeout_o, s_addr_o}), 128'd0);
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      m0_valid_i = 1'b1; m1_valid_i = 1'b1; s_ready_i = 1'b1; s_rdata_i = 32'h0000_00AB;
      @(negedge clk_i);
      chk("rst_idle", 128'({busy_o, m0_ready_o, m1_ready_o}), 128'(3'b000));
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("rst_first_tie", 128'({busy_o, grant_o, m0_ready_o, m1_ready_o, m0_rdata_o}),
          128'({4'b1010, 32'h0000_00AB}));
      @(posedge clk_i); #1;
      m0_valid_i = 1'b0; m1_valid_i = 1'b0; s_ready_i = 1'b0;
      @(negedge clk_i);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // absolute bound on run time
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the PicoRV-style native memory bus (valid/ready, addr, wdata, wstrb, rdata).
- Shares the single uart_ram slave between the CPU (master 0) and a secondary bus master (master 1, e.g. debug loader or DMA).
- Round-robin arbitration; one outstanding transaction at a time.
- A transaction timeout keeps a hung slave from stalling either master forever.

Parameters:
- TimeoutCycles, 1024: BUSY cycles without s_ready_i before a forced completion. 0 disables the timeout.
- ErrData, 32'hFFFF_FFFF: rdata returned to the master on a timed-out transaction.

Ports:
- clk_i  in  1  single clock
- reset_i  in  1  asynchronous, active-high reset
- m0_valid_i  in  1  master 0 request; held high until m0_ready_o
- m0_addr_i  in  32  master 0 address
- m0_wdata_i  in  32  master 0 write data
- m0_wstrb_i  in  4  master 0 byte strobes; 0 means read
- m0_rdata_o  out  32  master 0 read data, valid when m0_ready_o=1
- m0_ready_o  out  1  master 0 transaction complete, one-cycle pulse
- m1_valid_i, m1_addr_i, m1_wdata_i, m1_wstrb_i, m1_rdata_o, m1_ready_o: same as master 0, for master 1
- s_valid_o  out  1  request to slave
- s_addr_o  out  32  latched address to slave
- s_wdata_o  out  32  latched write data to slave
- s_wstrb_o  out  4  latched byte strobes to slave
- s_rdata_i  in  32  slave read data
- s_ready_i  in  1  slave completion
- grant_o  out  1  index of the master currently owning the bus; valid while busy_o=1
- busy_o  out  1  high in BUSY
- timeout_o  out  1  sticky flag; set on any timeout, cleared only by reset

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0; last_grant=1, so master 0 wins the first tie; timeout counter=0; latched addr/wdata/wstrb=0.
- IDLE:
  - s_valid_o=0, m*_ready_o=0.
  - If exactly one m*_valid_i is high, grant that master.
  - If both are high, grant the master that is not last_grant.
  - On grant, at the clock edge: latch that master's addr, wdata and wstrb; set grant_o; set last_grant=grant; clear the counter; move to BUSY.
  - If no request, stay in IDLE.
- BUSY:
  - s_valid_o=1, driven with the latched fields; busy_o=1; the counter increments each cycle.
  - Slave completion: when s_ready_i=1, assert m{grant}_ready_o combinationally in the same cycle, with m{grant}_rdata_o=s_rdata_i. Next state is IDLE.
  - Timeout: if s_ready_i=0, TimeoutCycles!=0 and the counter equals TimeoutCycles-1, assert m{grant}_ready_o in the same cycle with rdata=ErrData; set timeout_o; next state is IDLE.
  - If s_ready_i=1 and the timeout fire in the same cycle, s_ready_i wins: slave data is returned and timeout_o is not set.
- Non-granted master:
  - Its ready_o stays 0 and its rdata_o=0.
  - Its valid_i stays pending and wins the next IDLE cycle under the round-robin rule.
- Latency:
  - Request to grant: 1 cycle (IDLE to BUSY edge).
  - Slave sees s_valid_o the cycle after the master's valid_i rises.
  - Master completion is the same cycle as s_ready_i.
  - Minimum transaction is 2 cycles; back-to-back requests incur one IDLE cycle.
- Master inputs are sampled only at grant. Changes to addr/wdata/wstrb while BUSY have no effect.
- Reset asserted mid-BUSY: the transaction is abandoned with no ready pulse to either master; outputs return to reset values immediately.
- Counter width is clog2(TimeoutCycles+1); the counter saturates and never wraps.

Test Plan:
- Single read: m0_valid_i=1, addr=0x0000_0010, wstrb=0; slave returns s_ready_i=1 with 0x1234_5678 two cycles after s_valid_o rises -> s_addr_o=0x10, m0_ready_o pulses once, m0_rdata_o=0x1234_5678, m1_ready_o=0.
- Simultaneous requests after reset: m0 and m1 both valid, slave responds in 1 cycle -> grant order m0, m1, m0, m1 over 4 transactions, with one IDLE cycle between each.
- Write forwarding: m1 writes wdata=0xA5A5_A5A5, wstrb=0b0011, then changes m1_addr_i mid-BUSY -> s_wdata_o=0xA5A5_A5A5, s_wstrb_o=0b0011, s_addr_o unchanged throughout BUSY.
- Timeout: TimeoutCycles=8, s_ready_i held 0 -> m0_ready_o pulses 8 cycles after BUSY entry with rdata=0xFFFF_FFFF; timeout_o=1 and stays 1. Next transaction completes normally.
- Tie at the limit: s_ready_i=1 exactly on counter=TimeoutCycles-1 -> slave data returned, timeout_o stays 0.
- Reset mid-op: assert reset_i during BUSY -> s_valid_o, busy_o and m*_ready_o drop to 0 asynchronously. After release, the first tie is granted to m0.
